// File: rtl/reg_mux_n.sv
// reg_mux_n: registered NUM_IN-to-1 multiplexer of WIDTH-bit channels.
// Selection is either direct (sel) or a round-robin scan pointer. The mode
// input is used combinationally for each capture. The state register only
// tracks which mode was last in effect.
// Optional feature macro: REG_MUX_N_PARITY_EN adds par_out, the registered
// XOR reduction of the captured word.
module reg_mux_n #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic [WIDTH*NUM_IN-1:0] din,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    en,
  input  logic                    mode,
  output logic [WIDTH-1:0]        mux_out,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        cur_sel,
  output logic                    sel_err,
  output logic                    wrap
`ifdef REG_MUX_N_PARITY_EN
  ,
  output logic                    par_out
`endif
);

  // Last legal channel index, and the channel count widened by one bit so it
  // is representable even when NUM_IN == 2**SEL_W.
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_IN - 1);
  localparam logic [SEL_W:0]   NUM_IN_X = (SEL_W + 1)'(NUM_IN);

  typedef enum logic {
    ST_DIRECT = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] mux_out_q, mux_out_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic             sel_err_q, sel_err_d;
  logic             wrap_q, wrap_d;
  logic [SEL_W-1:0] scan_ptr_q, scan_ptr_d;

  logic [WIDTH-1:0] chan [NUM_IN];
  logic [SEL_W-1:0] capt_idx;
  logic             sel_in_range;
  logic [WIDTH-1:0] picked;
  logic [SEL_W-1:0] sel_succ;
  logic [SEL_W-1:0] scan_succ;

  // Unpack the flat channel bus into one word per channel.
  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_chan
      assign chan[gi] = din[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Index used for this cycle's capture, and range check of the direct select.
  assign capt_idx     = mode ? scan_ptr_q : sel;
  assign sel_in_range = ({1'b0, sel} < NUM_IN_X);
  assign sel_succ     = (sel == LAST_IDX) ? '0 : sel + SEL_W'(1);
  assign scan_succ    = (scan_ptr_q == LAST_IDX) ? '0 : scan_ptr_q + SEL_W'(1);

  // Channel pick by comparison so an out-of-range index yields zero.
  always_comb begin
    picked = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (capt_idx == SEL_W'(k)) begin
        picked = chan[k];
      end
    end
  end

  // Mode-tracking state: follows the mode input one cycle later.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_DIRECT: if (mode)  state_d = ST_SCAN;
      ST_SCAN:   if (!mode) state_d = ST_DIRECT;
      default:   state_d = ST_DIRECT;
    endcase
  end

  // Capture datapath next-state: hold on en=0, otherwise direct or scan capture.
  always_comb begin
    mux_out_d   = mux_out_q;
    out_valid_d = 1'b0;
    cur_sel_d   = cur_sel_q;
    sel_err_d   = sel_err_q;
    wrap_d      = 1'b0;
    scan_ptr_d  = scan_ptr_q;
    if (en) begin
      out_valid_d = 1'b1;
      cur_sel_d   = capt_idx;
      if (mode) begin
        mux_out_d  = picked;
        sel_err_d  = 1'b0;
        wrap_d     = (scan_ptr_q == LAST_IDX);
        scan_ptr_d = scan_succ;
      end else if (sel_in_range) begin
        mux_out_d  = picked;
        sel_err_d  = 1'b0;
        scan_ptr_d = sel_succ;
      end else begin
        mux_out_d  = '0;
        sel_err_d  = 1'b1;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= ST_DIRECT;
      mux_out_q   <= '0;
      out_valid_q <= 1'b0;
      cur_sel_q   <= '0;
      sel_err_q   <= 1'b0;
      wrap_q      <= 1'b0;
      scan_ptr_q  <= '0;
    end else begin
      state_q     <= state_d;
      mux_out_q   <= mux_out_d;
      out_valid_q <= out_valid_d;
      cur_sel_q   <= cur_sel_d;
      sel_err_q   <= sel_err_d;
      wrap_q      <= wrap_d;
      scan_ptr_q  <= scan_ptr_d;
    end
  end

  assign mux_out   = mux_out_q;
  assign out_valid = out_valid_q;
  assign cur_sel   = cur_sel_q;
  assign sel_err   = sel_err_q;
  assign wrap      = wrap_q;

`ifdef REG_MUX_N_PARITY_EN
  logic par_q, par_d;

  // Parity of the word being captured; out-of-range captures are zero, so
  // their parity is zero as well.
  always_comb begin
    par_d = par_q;
    if (en) begin
      par_d = ^mux_out_d;
    end
  end

  // Parity register, same enable and reset as the data register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign par_out = par_q;
`endif

endmodule

// File: tb/tb_reg_mux_n.sv
// Directed bench for reg_mux_n: a 4-channel and a 3-channel instance share
// clock, reset and control. Each step queues its expected outputs, then
// pops and compares them one edge later.
module tb_reg_mux_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din4;
  logic [1:0]  sel;
  logic        en;
  logic        mode;

  logic [7:0]  mux4, mux3;
  logic        v4, v3, err4, err3, wr4, wr3;
  logic [1:0]  cs4, cs3;
  logic        par4, par3;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    bit         dut3;
    logic [7:0] mux;
    logic       v;
    logic [1:0] cs;
    logic       err;
    logic       wr;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  reg_mux_n #(.WIDTH(8), .NUM_IN(4), .SEL_W(2)) u_dut4 (
    .CLK(clk), .Reset(rst), .din(din4), .sel(sel), .en(en), .mode(mode),
    .mux_out(mux4), .out_valid(v4), .cur_sel(cs4), .sel_err(err4), .wrap(wr4)
`ifdef REG_MUX_N_PARITY_EN
    , .par_out(par4)
`endif
  );

  reg_mux_n #(.WIDTH(8), .NUM_IN(3), .SEL_W(2)) u_dut3 (
    .CLK(clk), .Reset(rst), .din(din4[23:0]), .sel(sel), .en(en), .mode(mode),
    .mux_out(mux3), .out_valid(v3), .cur_sel(cs3), .sel_err(err3), .wrap(wr3)
`ifdef REG_MUX_N_PARITY_EN
    , .par_out(par3)
`endif
  );

`ifndef REG_MUX_N_PARITY_EN
  assign par4 = 1'b0;
  assign par3 = 1'b0;
`endif

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Queue the expectation, let one capture edge happen, then pop and compare.
  task automatic step(input string tag, input bit dut3, input logic [7:0] m,
                      input logic v, input logic [1:0] c, input logic e,
                      input logic w);
    exp_t x;
    exp_t got;
    x.dut3 = dut3; x.mux = m; x.v = v; x.cs = c; x.err = e; x.wr = w;
    sb.push_back(x);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    if (got.dut3) begin
      chk({tag, ".mux"}, mux3, got.mux);
      chk({tag, ".valid"}, {7'd0, v3}, {7'd0, got.v});
      chk({tag, ".cur_sel"}, {6'd0, cs3}, {6'd0, got.cs});
      chk({tag, ".sel_err"}, {7'd0, err3}, {7'd0, got.err});
      chk({tag, ".wrap"}, {7'd0, wr3}, {7'd0, got.wr});
`ifdef REG_MUX_N_PARITY_EN
      chk({tag, ".par"}, {7'd0, par3}, {7'd0, ^got.mux});
`endif
    end else begin
      chk({tag, ".mux"}, mux4, got.mux);
      chk({tag, ".valid"}, {7'd0, v4}, {7'd0, got.v});
      chk({tag, ".cur_sel"}, {6'd0, cs4}, {6'd0, got.cs});
      chk({tag, ".sel_err"}, {7'd0, err4}, {7'd0, got.err});
      chk({tag, ".wrap"}, {7'd0, wr4}, {7'd0, got.wr});
`ifdef REG_MUX_N_PARITY_EN
      chk({tag, ".par"}, {7'd0, par4}, {7'd0, ^got.mux});
`endif
    end
    $display("step %s: mux4=%h v4=%b cs4=%0d wr4=%b | mux3=%h v3=%b cs3=%0d err3=%b wr3=%b",
             tag, mux4, v4, cs4, wr4, mux3, v3, cs3, err3, wr3);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = 1'b0; sel = 2'd0; din4 = 32'hDDCCBBAA;

    // Reset dominates an active enable.
    step("rst0", 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
    step("rst1", 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
    step("rst1_d3", 1'b1, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);

    // Idle after release.
    rst = 1'b0; en = 1'b0;
    step("idle0", 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
    step("idle1", 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
    step("idle2", 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);

    // Direct select, then hold while din changes.
    en = 1'b1; sel = 2'd2;
    step("dir2", 1'b0, 8'hCC, 1'b1, 2'd2, 1'b0, 1'b0);
    en = 1'b0; din4 = 32'h11223344;
    step("hold", 1'b0, 8'hCC, 1'b0, 2'd2, 1'b0, 1'b0);
    din4 = 32'hDDCCBBAA;

    // Direct sel=1 leaves scan pointer at 2, then scan through a wrap.
    en = 1'b1; sel = 2'd1;
    step("dir1", 1'b0, 8'hBB, 1'b1, 2'd1, 1'b0, 1'b0);
    mode = 1'b1; sel = 2'd0;
    step("scan_a", 1'b0, 8'hCC, 1'b1, 2'd2, 1'b0, 1'b0);
    step("scan_b", 1'b0, 8'hDD, 1'b1, 2'd3, 1'b0, 1'b1);
    step("scan_c", 1'b0, 8'hAA, 1'b1, 2'd0, 1'b0, 1'b0);
    step("scan_d", 1'b0, 8'hBB, 1'b1, 2'd1, 1'b0, 1'b0);

    // Mode switch mid-scan takes effect on the very next capture.
    step("scan_e", 1'b0, 8'hCC, 1'b1, 2'd2, 1'b0, 1'b0);
    step("scan_f", 1'b0, 8'hDD, 1'b1, 2'd3, 1'b0, 1'b1);
    mode = 1'b0; sel = 2'd0;
    step("sw_dir0", 1'b0, 8'hAA, 1'b1, 2'd0, 1'b0, 1'b0);
    mode = 1'b1;
    step("sw_scan1", 1'b0, 8'hBB, 1'b1, 2'd1, 1'b0, 1'b0);

    // Reset while scan pointer is 2; scan restarts at channel 0.
    rst = 1'b1;
    step("rst_mid", 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step("post_rst", 1'b0, 8'hAA, 1'b1, 2'd0, 1'b0, 1'b0);

    // Parity-bearing word captured directly (parity checked when enabled).
    mode = 1'b0; sel = 2'd0; din4 = 32'hDDCCBB07;
    step("par07", 1'b0, 8'h07, 1'b1, 2'd0, 1'b0, 1'b0);
    din4 = 32'hDDCCBBAA;

    // Three-channel instance: out-of-range select, recovery, scan wrap at 2.
    sel = 2'd3;
    step("oor", 1'b1, 8'h00, 1'b1, 2'd3, 1'b1, 1'b0);
    en = 1'b0;
    step("oor_hold", 1'b1, 8'h00, 1'b0, 2'd3, 1'b1, 1'b0);
    en = 1'b1; sel = 2'd0;
    step("oor_clr", 1'b1, 8'hAA, 1'b1, 2'd0, 1'b0, 1'b0);
    mode = 1'b1;
    step("s3_a", 1'b1, 8'hBB, 1'b1, 2'd1, 1'b0, 1'b0);
    step("s3_b", 1'b1, 8'hCC, 1'b1, 2'd2, 1'b0, 1'b1);
    step("s3_c", 1'b1, 8'hAA, 1'b1, 2'd0, 1'b0, 1'b0);

    // Scoreboard must be drained.
    total_cnt++;
    assert (sb.size() == 0) pass_cnt++;
    else $error("FAIL sb_empty observed=%0d expected=0", sb.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
